// File: rtl/core_pkg.sv
// Shared types for the core pipeline: register-address width, the shadow
// stage record, and the per-cycle action chosen by the hazard sequencer.
package core_pkg;

  localparam int unsigned RA_W = 5;

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            ld;
  } stage_rec_t;

  localparam logic [RA_W-1:0] REG_ZERO = '0;

  localparam stage_rec_t BUBBLE = '{v: 1'b0, rd: REG_ZERO, we: 1'b0, ld: 1'b0};

  // What the pipe does this cycle, in priority order freeze > redirect > raw.
  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_FREEZE   = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_RAW      = 2'd3
  } hz_act_e;

endpackage

// File: rtl/hazard_match.sv
// Combinational RAW check of the ID instruction's sources against one
// in-flight writer slot.
module hazard_match
  import core_pkg::*;
(
  input  stage_rec_t       slot,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  rs1,
  input  logic [RA_W-1:0]  rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic             match_c
);

  logic writer_live;
  logic src_hit;

  // x0 is hardwired, so a writer targeting it never creates a dependency.
  assign writer_live = slot.v & slot.we & (slot.rd != REG_ZERO);
  assign src_hit     = (rs1_used & (rs1 == slot.rd)) | (rs2_used & (rs2 == slot.rd));
  assign match_c     = id_valid & writer_live & src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: tracks EX/MEM/WB writers and
// turns RAW hazards, EX redirects and memory back-pressure into stage controls.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter bit          FWD_EN = 1'b0,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_we_i,
  input  logic             id_load_i,
  input  logic             ex_redirect_i,
  input  logic             mem_busy_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             freeze_o,
  output logic             raw_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_rec_t       ex_q;
  stage_rec_t       mem_q;
  stage_rec_t       wb_q;
  stage_rec_t       id_rec;
  hz_act_e          act;
  logic             ex_hit_c;
  logic             mem_hit_c;
  logic             raw_c;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             unused_wb;

  hazard_match u_ex_match (
    .slot     (ex_q),
    .id_valid (id_valid_i),
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .rs1_used (id_rs1_used_i),
    .rs2_used (id_rs2_used_i),
    .match_c  (ex_hit_c)
  );

  hazard_match u_mem_match (
    .slot     (mem_q),
    .id_valid (id_valid_i),
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .rs1_used (id_rs1_used_i),
    .rs2_used (id_rs2_used_i),
    .match_c  (mem_hit_c)
  );

  assign id_rec = '{v: id_valid_i, rd: id_rd_i, we: id_we_i, ld: id_load_i};

  // With forwarding only a load in EX is too late; without it EX and MEM both
  // block. WB is safe because the register file writes before it reads.
  always_comb begin
    raw_c = 1'b0;
    if (FWD_EN) raw_c = ex_hit_c & ex_q.ld;
    else        raw_c = ex_hit_c | mem_hit_c;
  end

  // Action select and stage controls.
  always_comb begin
    act         = ACT_RUN;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    freeze_o    = 1'b0;
    raw_stall_o = 1'b0;
    if (mem_busy_i) begin
      act        = ACT_FREEZE;
      freeze_o   = 1'b1;
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
    end else if (ex_redirect_i) begin
      // ID holds a wrong-path instruction, so any hazard it shows is moot.
      act        = ACT_REDIRECT;
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (raw_c) begin
      act         = ACT_RAW;
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      flush_ex_o  = 1'b1;
      raw_stall_o = 1'b1;
    end
  end

  // Shadow of in-flight writers; a bubble enters EX on redirect or stall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (act != ACT_FREEZE) begin
      ex_q  <= (act == ACT_RUN) ? id_rec : BUBBLE;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Saturating perf counters; frozen cycles count as neither.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act == ACT_RAW && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (act == ACT_REDIRECT && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // WB slot is a debug probe only.
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: both forwarding modes run side by side against a
// queue-style pipeline model, with directed cases followed by random traffic.
module tb_pipe_hazard_ctrl;
  import core_pkg::*;

  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = 15;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [RA_W-1:0] id_rd;
  logic            id_we;
  logic            id_load;
  logic            ex_redirect;
  logic            mem_busy;

  logic          s_if [2];
  logic          s_id [2];
  logic          f_id [2];
  logic          f_ex [2];
  logic          frz  [2];
  logic          raw  [2];
  logic [CW-1:0] scnt [2];
  logic [CW-1:0] fcnt [2];

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(CW)) u_nofwd (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
    .ex_redirect_i(ex_redirect), .mem_busy_i(mem_busy),
    .stall_if_o(s_if[0]), .stall_id_o(s_id[0]), .flush_id_o(f_id[0]),
    .flush_ex_o(f_ex[0]), .freeze_o(frz[0]), .raw_stall_o(raw[0]),
    .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(CW)) u_fwd (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
    .ex_redirect_i(ex_redirect), .mem_busy_i(mem_busy),
    .stall_if_o(s_if[1]), .stall_id_o(s_id[1]), .flush_id_o(f_id[1]),
    .flush_ex_o(f_ex[1]), .freeze_o(frz[1]), .raw_stall_o(raw[1]),
    .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per mode, the writers ahead of ID listed youngest first (EX, MEM, WB).
  typedef struct {
    bit          v;
    int unsigned rd;
    bit          we;
    bit          ld;
  } mrec_t;

  mrec_t       pl [2][3];
  int unsigned mst [2];
  int unsigned mfl [2];
  int          nvec;
  int          nerr;

  function automatic bit reads_from(mrec_t p);
    bit hit;
    hit = (id_rs1_used && int'(id_rs1) == p.rd) || (id_rs2_used && int'(id_rs2) == p.rd);
    return id_valid && p.v && p.we && p.rd != 0 && hit;
  endfunction

  function automatic bit hazard(int m);
    if (m == 1) return reads_from(pl[m][0]) && pl[m][0].ld;
    return reads_from(pl[m][0]) || reads_from(pl[m][1]);
  endfunction

  // {stall_if, stall_id, flush_id, flush_ex, freeze, raw_stall}
  function automatic logic [5:0] exp_ctrl(int m);
    if (mem_busy)    return 6'b110010;
    if (ex_redirect) return 6'b001100;
    if (hazard(m))   return 6'b110101;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] obs_ctrl(int m);
    return {s_if[m], s_id[m], f_id[m], f_ex[m], frz[m], raw[m]};
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 3; s++) pl[m][s] = '{0, 0, 0, 0};
      mst[m] = 0;
      mfl[m] = 0;
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      bit    r;
      mrec_t n;
      if (mem_busy) continue;
      r = hazard(m);
      if (ex_redirect || r) n = '{0, 0, 0, 0};
      else n = '{id_valid, int'(id_rd), id_we, id_load};
      pl[m][2] = pl[m][1];
      pl[m][1] = pl[m][0];
      pl[m][0] = n;
      if (ex_redirect) begin
        if (mfl[m] < SAT) mfl[m]++;
      end else if (r) begin
        if (mst[m] < SAT) mst[m]++;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_ctrl_m%0d", tag, m), 32'(obs_ctrl(m)), 32'(exp_ctrl(m)));
      chk($sformatf("%s_cnt_m%0d", tag, m), {24'd0, scnt[m], fcnt[m]},
          {24'd0, CW'(mst[m]), CW'(mfl[m])});
    end
  endtask

  // Inputs are already set at the falling edge; check, then clock one cycle.
  task automatic step(string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, bit ld);
    id_valid    = v;
    id_rs1      = RA_W'(rs1);
    id_rs1_used = u1;
    id_rs2      = RA_W'(rs2);
    id_rs2_used = u2;
    id_rd       = RA_W'(rd);
    id_we       = we;
    id_load     = ld;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ctrl_m0", 32'(obs_ctrl(0)), 32'd0);
    chk("reset_cnt_m1", {24'd0, scnt[1], fcnt[1]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    do_reset();

    // Back-to-back dependency without forwarding: two stalls; none with forwarding.
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    step("t1_add");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1 chk("t1_c1_stall_id", 32'(s_id[0]), 32'd1);
    chk("t1_c1_fwd_nostall", 32'(s_id[1]), 32'd0);
    step("t1_c1");
    #1 chk("t1_c2_stall_id", 32'(s_id[0]), 32'd1);
    step("t1_c2");
    #1 chk("t1_c3_release", 32'(s_id[0]), 32'd0);
    step("t1_c3");
    chk("t1_stall_cnt", 32'(scnt[0]), 32'd2);
    chk("t1_fwd_stall_cnt", 32'(scnt[1]), 32'd0);

    // Load-use with forwarding: one stall cycle with a bubble into EX.
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    step("t2_lw");
    set_id(1, 3, 1, 7, 1, 8, 1, 0);
    #1 chk("t2_c1_stall_id", 32'(s_id[1]), 32'd1);
    chk("t2_c1_flush_ex", 32'(f_ex[1]), 32'd1);
    step("t2_c1");
    #1 chk("t2_c2_release", 32'(s_id[1]), 32'd0);
    step("t2_c2");
    step("t2_c3");
    chk("t2_fwd_stall_cnt", 32'(scnt[1]), 32'd1);

    // x0 writer and unused rs2 never stall.
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    step("t3_wr_x0");
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    #1 chk("t3_x0_nostall", 32'(s_id[0]), 32'd0);
    step("t3_rd_x0");
    set_id(1, 0, 0, 0, 0, 9, 1, 1);
    step("t3_wr_x9");
    set_id(1, 3, 1, 9, 0, 4, 1, 0);
    #1 chk("t3_rs2_unused", {30'd0, s_id[0], s_id[1]}, 32'd0);
    step("t3_rs2_unused");

    // Redirect overrides a pending RAW.
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    step("t4_add");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    ex_redirect = 1'b1;
    #1 chk("t4_flush", {28'd0, f_id[0], f_ex[0], s_id[0], s_if[0]}, 32'b1100);
    step("t4_redirect");
    ex_redirect = 1'b0;
    chk("t4_cnts", {24'd0, scnt[0], fcnt[0]}, 32'h01);

    // Freeze in the middle of a RAW stall, then finish the remaining stall cycle.
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    step("t5_add");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    step("t5_raw1");
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_freeze", {30'd0, frz[0], raw[0]}, 32'b10);
      step("t5_busy");
    end
    mem_busy = 1'b0;
    #1 chk("t5_resume_stall", 32'(s_id[0]), 32'd1);
    step("t5_raw2");
    #1 chk("t5_release", 32'(s_id[0]), 32'd0);
    step("t5_run");
    chk("t5_stall_cnt", 32'(scnt[0]), 32'd2);

    // Counter saturation, then asynchronous reset during a stall.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      step("t6_prod");
      set_id(1, 5, 1, 0, 0, 0, 0, 0);
      step("t6_dep");
      step("t6_dep");
      step("t6_dep");
    end
    ex_redirect = 1'b1;
    for (int i = 0; i < 20; i++) step("t6_redir");
    ex_redirect = 1'b0;
    chk("t6_sat", {24'd0, scnt[0], fcnt[0]}, 32'hFF);
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    step("t6_prod2");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1 chk("t6_pre_rst_stall", 32'(s_id[0]), 32'd1);
    rst_n = 1'b0;
    #1 chk("t6_async_ctrl", {26'd0, obs_ctrl(0)}, 32'd0);
    chk("t6_async_cnt", {24'd0, scnt[0], fcnt[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    step("t6_post_rst");

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 600; i++) begin
      set_id(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_busy    = ($urandom_range(0, 6) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
